// File: rtl/rf_dbg_port_arbiter_pkg.sv
// Shared types for the register-file debug port arbiter.
package rf_arb_pkg;

  // Width of the latched debug write data; matches the default XLEN of the arbiter.
  localparam int RF_XLEN = 32;

  localparam logic [4:0] X0_IDX = 5'd0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    RD_DATA = 2'd2,
    ACK     = 2'd3
  } state_e;

  // Debug access captured when it is accepted in IDLE.
  typedef struct packed {
    logic               we;
    logic [4:0]         addr;
    logic [RF_XLEN-1:0] wdata;
  } dbg_req_t;

endpackage

// File: rtl/rf_dbg_port_arbiter_wait_timer.sv
// Bounded-wait timer: counts ungranted wait cycles and raises a registered
// stall once the debug access has waited MAX_WAIT cycles.
module rf_arb_wait_timer #(
  parameter int MAX_WAIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_stall
);

  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_WAIT);
  localparam logic [CW-1:0] THR_C = CW'(MAX_WAIT - 1);

  logic [CW-1:0] r_cnt;
  logic          r_stall;

  // Saturating count of ungranted cycles; stall follows the enable so it
  // drops on the edge that ends the grant cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_stall <= 1'b0;
    end else begin
      if (i_clr)
        r_cnt <= '0;
      else if (i_en && (r_cnt != MAX_C))
        r_cnt <= r_cnt + 1'b1;
      r_stall <= i_en && (r_cnt >= THR_C);
    end
  end

  assign o_stall = r_stall;

endmodule

// File: rtl/rf_dbg_port_arbiter.sv
// Shares int_rf read port 1 and the write port between the pipeline and the
// debug unit. The pipeline always wins; debug uses idle cycles and a wait
// timer forces a pipeline stall if it is held off too long.
module rf_dbg_port_arbiter
  import rf_arb_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int MAX_WAIT = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pl_rd_req,
  input  logic [4:0]      pl_src1,
  input  logic [4:0]      pl_src2,
  input  logic            pl_we,
  input  logic [4:0]      pl_dst,
  input  logic [XLEN-1:0] pl_wdata,
  input  logic            dbg_req,
  input  logic            dbg_we,
  input  logic [4:0]      dbg_addr,
  input  logic [XLEN-1:0] dbg_wdata,
  output logic            dbg_ack,
  output logic [XLEN-1:0] dbg_rdata,
  output logic            pl_stall,
  output logic [4:0]      rf_src1,
  output logic [4:0]      rf_src2,
  input  logic [XLEN-1:0] rf_src1_q,
  output logic            rf_we,
  output logic [4:0]      rf_dst,
  output logic [XLEN-1:0] rf_wdata
);

  state_e          r_state, w_next;
  dbg_req_t        r_req;
  logic [XLEN-1:0] r_rdata;

  logic w_rd_grant, w_wr_grant, w_x0_rd;

  assign w_rd_grant = (r_state == WAIT) && !r_req.we && !pl_rd_req;
  assign w_wr_grant = (r_state == WAIT) &&  r_req.we && !pl_we;
  assign w_x0_rd    = !dbg_we && (dbg_addr == X0_IDX);

  // Next state and port muxing; the pipeline passes through except in a grant cycle.
  always_comb begin
    w_next   = r_state;
    rf_src1  = pl_src1;
    rf_we    = pl_we;
    rf_dst   = pl_dst;
    rf_wdata = pl_wdata;
    case (r_state)
      IDLE: begin
        if (dbg_req) w_next = w_x0_rd ? ACK : WAIT;
      end
      WAIT: begin
        if (w_rd_grant) begin
          rf_src1 = r_req.addr;
          w_next  = RD_DATA;
        end else if (w_wr_grant) begin
          // x0 is hardwired zero: complete the access without touching the file.
          if (r_req.addr != X0_IDX) begin
            rf_we    = 1'b1;
            rf_dst   = r_req.addr;
            rf_wdata = r_req.wdata;
          end
          w_next = ACK;
        end
      end
      RD_DATA: w_next = ACK;
      ACK:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // State register, request latch and read-result holding register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_req   <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_next;
      if ((r_state == IDLE) && dbg_req) begin
        r_req <= '{we: dbg_we, addr: dbg_addr, wdata: dbg_wdata};
        if (w_x0_rd) r_rdata <= '0;
      end
      if (r_state == RD_DATA) r_rdata <= rf_src1_q;
    end
  end

  rf_arb_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (r_state == IDLE),
    .i_en    ((r_state == WAIT) && !w_rd_grant && !w_wr_grant),
    .o_stall (pl_stall)
  );

  assign dbg_ack   = (r_state == ACK);
  assign dbg_rdata = r_rdata;
  assign rf_src2   = pl_src2;

endmodule

// File: tb/tb_rf_dbg_port_arbiter.sv
// Bench for rf_dbg_port_arbiter: int_rf behavioural model, per-transaction
// reference expectations derived from grant timing, random pipeline traffic.
module tb_rf_dbg_port_arbiter;

  localparam int MW = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        pl_rd_req, pl_we, dbg_req, dbg_we;
  logic [4:0]  pl_src1, pl_src2, pl_dst, dbg_addr;
  logic [31:0] pl_wdata, dbg_wdata;
  logic        dbg_ack, pl_stall, rf_we;
  logic [31:0] dbg_rdata, rf_wdata, rf_src1_q;
  logic [4:0]  rf_src1, rf_src2, rf_dst;

  logic [31:0] mem [32];
  logic [31:0] shadow [32];
  logic [31:0] last_rdata;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  rf_dbg_port_arbiter #(.XLEN(32), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst),
    .pl_rd_req(pl_rd_req), .pl_src1(pl_src1), .pl_src2(pl_src2),
    .pl_we(pl_we), .pl_dst(pl_dst), .pl_wdata(pl_wdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata), .pl_stall(pl_stall),
    .rf_src1(rf_src1), .rf_src2(rf_src2), .rf_src1_q(rf_src1_q),
    .rf_we(rf_we), .rf_dst(rf_dst), .rf_wdata(rf_wdata)
  );

  // int_rf: registered read on port 1, x0 never written.
  always @(posedge clk) begin
    rf_src1_q <= mem[rf_src1];
    if (rf_we && (rf_dst != 5'd0)) mem[rf_dst] <= rf_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Random pipeline traffic; 'busy' drives the signal that blocks the pending access kind.
  task automatic drive_pl(input logic busy, input logic wr_kind);
    pl_rd_req = wr_kind ? 1'($urandom) : busy;
    pl_we     = wr_kind ? busy : 1'($urandom);
    pl_src1   = 5'($urandom);
    pl_src2   = 5'($urandom);
    pl_dst    = 5'($urandom);
    pl_wdata  = $urandom;
  endtask

  task automatic cyc(input logic e_ack, input logic e_stall, input logic [4:0] e_src1,
                     input logic e_we, input logic [4:0] e_dst, input logic [31:0] e_wd,
                     input logic [31:0] e_rd);
    @(negedge clk);
    chk("dbg_ack",   {31'd0, dbg_ack},  {31'd0, e_ack});
    chk("pl_stall",  {31'd0, pl_stall}, {31'd0, e_stall});
    chk("rf_src1",   {27'd0, rf_src1},  {27'd0, e_src1});
    chk("rf_src2",   {27'd0, rf_src2},  {27'd0, pl_src2});
    chk("rf_we",     {31'd0, rf_we},    {31'd0, e_we});
    chk("rf_dst",    {27'd0, rf_dst},   {27'd0, e_dst});
    chk("rf_wdata",  rf_wdata, e_wd);
    chk("dbg_rdata", dbg_rdata, e_rd);
    if (e_we && (e_dst != 5'd0)) shadow[e_dst] = e_wd;
    @(posedge clk); #1;
  endtask

  task automatic idle_cyc(input logic quiet);
    dbg_req = 1'b0;
    drive_pl(quiet ? 1'b0 : 1'($urandom), 1'b1);
    cyc(1'b0, 1'b0, pl_src1, pl_we, pl_dst, pl_wdata, last_rdata);
  endtask

  // One debug access. Expectations come from the grant cycle: first WAIT cycle
  // where the blocking pipeline signal is low; read acks two cycles later,
  // write one later, x0 read acks right after acceptance.
  task automatic run_txn(input logic we, input logic [4:0] addr, input logic [31:0] wd,
                         input int force_busy, input int pct, input int abort_at);
    logic x0rd, busy, e_stall, e_we, done;
    logic [4:0]  e_src1, e_dst;
    logic [31:0] e_wd, exp_val;
    int grant_j, ack_j;
    x0rd = !we && (addr == 5'd0);
    grant_j = 0;
    ack_j = x0rd ? 1 : 0;
    exp_val = 32'd0;
    done = 1'b0;
    idle_cyc(1'b0);
    dbg_req = 1'b1; dbg_we = we; dbg_addr = addr; dbg_wdata = wd;
    drive_pl(1'($urandom), we);
    cyc(1'b0, 1'b0, pl_src1, pl_we, pl_dst, pl_wdata, last_rdata);
    for (int j = 1; j <= 300 && !done; j++) begin
      // Request fields may wander after acceptance; the latched copy must not.
      dbg_we = 1'($urandom); dbg_addr = 5'($urandom); dbg_wdata = $urandom;
      busy = (j <= force_busy) || ($urandom_range(0, 99) < pct);
      drive_pl(busy, we);
      if (!x0rd && grant_j == 0 && !busy && j != abort_at) begin
        grant_j = j;
        ack_j = we ? j + 1 : j + 2;
        if (!we) exp_val = shadow[addr];
      end
      e_stall = !x0rd && (j >= MW + 1) && (grant_j == 0 || j <= grant_j);
      e_src1  = (!we && !x0rd && j == grant_j) ? addr : pl_src1;
      if (we && j == grant_j && addr != 5'd0) begin
        e_we = 1'b1; e_dst = addr; e_wd = wd;
      end else begin
        e_we = pl_we; e_dst = pl_dst; e_wd = pl_wdata;
      end
      if (j == ack_j && !we) last_rdata = x0rd ? 32'd0 : exp_val;
      if (j == abort_at) rst = 1'b1;
      cyc(j == ack_j, e_stall, e_src1, e_we, e_dst, e_wd, last_rdata);
      if (j == abort_at) begin
        rst = 1'b0;
        done = 1'b1;
      end else if (j == ack_j) begin
        done = 1'b1;
      end
    end
    chk("txn_done", {31'd0, done}, 32'd1);
    dbg_req = 1'b0;
    if (abort_at > 0) begin
      last_rdata = 32'd0;
      repeat (3) idle_cyc(1'b1);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      mem[i] = (i == 0) ? 32'd0 : $urandom;
    end
    mem[5] = 32'hDEADBEEF;
    for (int i = 0; i < 32; i++) shadow[i] = mem[i];
    last_rdata = 32'd0;
    rst = 1'b1;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = 5'd0; dbg_wdata = 32'd0;
    pl_rd_req = 1'b0; pl_we = 1'b0; pl_src1 = 5'd0; pl_src2 = 5'd0;
    pl_dst = 5'd0; pl_wdata = 32'd0;
    @(posedge clk); #1;
    // Reset state held for two cycles.
    repeat (2) cyc(1'b0, 1'b0, pl_src1, pl_we, pl_dst, pl_wdata, 32'd0);
    rst = 1'b0;

    run_txn(1'b0, 5'd5, 32'd0,         0, 0, 0);   // read x5, immediate grant
    run_txn(1'b1, 5'd7, 32'h0000_1234, 3, 0, 0);   // write x7 behind 3 pipeline writes
    run_txn(1'b0, 5'd7, 32'd0,         0, 0, 0);   // read back x7
    run_txn(1'b0, 5'd5, 32'd0,         6, 0, 0);   // long wait, forced stall
    run_txn(1'b1, 5'd0, 32'h0000_FFFF, 0, 0, 0);   // write x0: ack, no write
    run_txn(1'b0, 5'd0, 32'd0,         0, 0, 0);   // read x0: short path
    run_txn(1'b1, 5'd9, 32'hAAAA_5555, 10, 0, 7);  // reset while stalled in WAIT
    run_txn(1'b1, 5'd31, 32'h0BAD_F00D, MW, 0, 0); // grant exactly when stall rises

    for (int t = 0; t < 40; t++) begin
      run_txn(1'($urandom), 5'($urandom), $urandom,
              $urandom_range(0, 7), $urandom_range(0, 70), 0);
    end
    idle_cyc(1'b1);

    for (int i = 0; i < 32; i++) chk($sformatf("rf[%0d]", i), mem[i], shadow[i]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
